// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-side signals of the shared-memory
// arbiter. The slave modport is the arbiter; the master modport is the
// surrounding system (both requesters plus the memory array).
interface mem_arbiter_if;
  // instruction-fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  // data load/store requester
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_err;
  // unified memory array
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  // status
  logic        busy;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_ack, if_rdata, if_err,
    output dm_ack, dm_rdata, dm_err,
    output mem_addr, mem_we, mem_be, mem_wdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_ack, if_rdata, if_err,
    input  dm_ack, dm_rdata, dm_err,
    input  mem_addr, mem_we, mem_be, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-addressed 32-bit little-endian memory between
// the fetch and data requesters. One access at a time: IDLE -> WAIT (x N) ->
// ACK -> IDLE. Read data is captured into per-requester registers at the end
// of the ACK cycle; stores pulse mem_we during ACK only. Misaligned requests
// skip the memory and are acknowledged with err set.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration; without
// it the data requester has fixed priority over fetch.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2  // wait states per access, 0..15
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sel_dm_q, sel_dm_d;   // granted requester: 1 = data, 0 = fetch
  logic        we_q, we_d;           // granted access is a store
  logic        err_q, err_d;         // granted access is misaligned
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;

  logic        any_req;
  logic        grant_dm;
  logic [31:0] req_addr;
  logic        req_misaligned;

`ifdef MEM_ARB_RR_EN
  // 1 = fetch is favoured on the next contended grant
  logic rr_fetch_q, rr_fetch_d;

  // round-robin pointer: after serving data favour fetch and vice versa
  always_ff @(posedge clk) begin
    if (rst) rr_fetch_q <= 1'b1;
    else     rr_fetch_q <= rr_fetch_d;
  end

  // pointer moves only when a transaction completes its ACK cycle
  always_comb begin
    rr_fetch_d = rr_fetch_q;
    if (state_q == S_ACK) rr_fetch_d = sel_dm_q;
  end

  // grant data unless fetch is also asking and fetch is favoured
  always_comb begin
    grant_dm = bus.dm_req && !(bus.if_req && rr_fetch_q);
  end
`else
  // fixed priority: data always wins
  always_comb begin
    grant_dm = bus.dm_req;
  end
`endif

  // request-side decode used only in IDLE
  always_comb begin
    any_req        = bus.if_req || bus.dm_req;
    req_addr       = grant_dm ? bus.dm_addr : bus.if_addr;
    req_misaligned = (req_addr[1:0] != 2'b00);
  end

  // state and datapath registers; reset drops any in-flight transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      sel_dm_q    <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_dm_q    <= sel_dm_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // next-state: grant and latch in IDLE, count wait states, capture in ACK
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_dm_d    = sel_dm_q;
    we_d        = we_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          sel_dm_d = grant_dm;
          we_d     = grant_dm && bus.dm_we;
          err_d    = req_misaligned;
          if (req_misaligned) begin
            // no memory access: memory-side registers keep their value
            state_d = S_ACK;
          end else begin
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (grant_dm && bus.dm_we) begin
              mem_be_d    = bus.dm_be;
              mem_wdata_d = bus.dm_wdata;
            end
            cnt_d   = WAIT_INIT;
            state_d = NO_WAIT ? S_ACK : S_WAIT;
          end
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_ACK;
      end

      S_ACK: begin
        // read data is sampled at the edge that ends ACK; stores and
        // misaligned accesses leave the read registers untouched
        if (!err_q && !we_q) begin
          if (sel_dm_q) dm_rdata_d = bus.mem_rdata;
          else          if_rdata_d = bus.mem_rdata;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // outputs decoded from registered state only
  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.if_ack    = (state_q == S_ACK) && !sel_dm_q;
    bus.dm_ack    = (state_q == S_ACK) &&  sel_dm_q;
    bus.if_err    = bus.if_ack && err_q;
    bus.dm_err    = bus.dm_ack && err_q;
    bus.mem_we    = (state_q == S_ACK) && sel_dm_q && we_q && !err_q;
    bus.mem_addr  = mem_addr_q;
    bus.mem_be    = mem_be_q;
    bus.mem_wdata = mem_wdata_q;
    bus.if_rdata  = if_rdata_q;
    bus.dm_rdata  = dm_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Two instances share the
// clock and reset: dut (WAIT_CYCLES=2) and dut0 (WAIT_CYCLES=0), each with
// its own behavioural memory. Expected acks (port, cycle, err, read data) are
// queued when a request is driven and checked when the ack appears.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter_if bus0();

  mem_arbiter #(.WAIT_CYCLES(2)) dut  (.clk(clk), .rst(rst), .bus(bus));
  mem_arbiter #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  typedef struct {
    bit          dm;
    bit          err;
    logic [31:0] rdata;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          we_cnt  = 0;
  int          dmack_cnt = 0;
  logic [31:0] m_if_rdata = 32'd0;
  logic [31:0] m_dm_rdata = 32'd0;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      2:       return 32'h014B4820;
      4:       return 32'h11223344;
      default: return 32'hA5A50000 | 32'(i);
    endcase
  endfunction

  logic [31:0] mem_a [0:15];
  logic [31:0] mem_b [0:15];

  // memories: combinational read, byte-enabled synchronous write
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mem_a[i] <= init_word(i);
        mem_b[i] <= init_word(i);
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_we && bus.mem_be[b])
          mem_a[bus.mem_addr[5:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        if (bus0.mem_we && bus0.mem_be[b])
          mem_b[bus0.mem_addr[5:2]][8*b +: 8] <= bus0.mem_wdata[8*b +: 8];
      end
    end
  end
  assign bus.mem_rdata  = mem_a[bus.mem_addr[5:2]];
  assign bus0.mem_rdata = mem_b[bus0.mem_addr[5:2]];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_we) we_cnt    <= we_cnt + 1;
    if (bus.dm_ack) dmack_cnt <= dmack_cnt + 1;
  end

  // waits (bounded) for the next ack on dut; returns the port, cycle and err
  task automatic wait_any_ack(input int budget, output bit got, output bit dm,
                              output int at, output bit err);
    got = 1'b0; dm = 1'b0; at = -1; err = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.if_ack || bus.dm_ack) begin
        got = 1'b1;
        dm  = bus.dm_ack;
        at  = cyc;
        err = bus.dm_ack ? bus.dm_err : bus.if_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.busy, bus.if_ack, bus.dm_ack, bus.if_err, bus.dm_err, bus.mem_we} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 000000",
               {bus.busy, bus.if_ack, bus.dm_ack, bus.if_err, bus.dm_err, bus.mem_we});
    end
    n_tests++;
    if ({bus.if_rdata, bus.dm_rdata} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h %h want 0 0", bus.if_rdata, bus.dm_rdata);
    end
    n_tests++;
    if ({bus.mem_addr, bus.mem_be, bus.mem_wdata} !== 68'd0) begin
      n_fail++;
      $display("FAIL reset_mem: got %h %h %h want 0 0 0", bus.mem_addr, bus.mem_be, bus.mem_wdata);
    end
    n_tests++;
    if (bus0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy0: got %b want 0", bus0.busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    exp_t e; bit got, dm, err; int at, t0, w0;
    t0 = cyc; w0 = we_cnt;
    bus.if_addr = 32'h8; bus.if_req = 1'b1;
    sb.push_back('{dm: 1'b0, err: 1'b0, rdata: 32'h014B4820, at: t0 + 3});
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL fetch_busy: got %b want 1", bus.busy); end
    wait_any_ack(10, got, dm, at, err);
    e = sb.pop_front();
    n_tests++;
    if (!got || dm !== e.dm || at != e.at || err !== e.err) begin
      n_fail++;
      $display("FAIL fetch_ack: got ack=%0b dm=%0b cyc=%0d err=%0b want dm=%0b cyc=%0d err=%0b",
               got, dm, at - t0, err, e.dm, e.at - t0, e.err);
    end
    n_tests++;
    if (bus.mem_addr !== 32'h8) begin n_fail++; $display("FAIL fetch_addr: got %h want 00000008", bus.mem_addr); end
    @(negedge clk);
    bus.if_req = 1'b0;
    m_if_rdata = e.rdata;
    n_tests++;
    if (bus.if_rdata !== m_if_rdata) begin
      n_fail++; $display("FAIL fetch_rdata: got %h want %h", bus.if_rdata, m_if_rdata);
    end
    n_tests++;
    if (we_cnt != w0) begin n_fail++; $display("FAIL fetch_no_we: got %0d pulses want 0", we_cnt - w0); end
  endtask

  task automatic test_store_load();
    exp_t e; bit got, dm, err; int at, t0, w0;
    t0 = cyc; w0 = we_cnt;
    bus.dm_addr = 32'h10; bus.dm_we = 1'b1; bus.dm_be = 4'b0011;
    bus.dm_wdata = 32'hAABBCCDD; bus.dm_req = 1'b1;
    sb.push_back('{dm: 1'b1, err: 1'b0, rdata: m_dm_rdata, at: t0 + 3});
    wait_any_ack(10, got, dm, at, err);
    e = sb.pop_front();
    n_tests++;
    if (!got || dm !== e.dm || at != e.at || err !== e.err) begin
      n_fail++;
      $display("FAIL store_ack: got ack=%0b dm=%0b cyc=%0d err=%0b want dm=%0b cyc=%0d err=%0b",
               got, dm, at - t0, err, e.dm, e.at - t0, e.err);
    end
    n_tests++;
    if ({bus.mem_we, bus.mem_be} !== 5'b1_0011) begin
      n_fail++; $display("FAIL store_we: got we=%b be=%b want we=1 be=0011", bus.mem_we, bus.mem_be);
    end
    @(negedge clk);
    n_tests++;
    if (bus.dm_rdata !== e.rdata) begin
      n_fail++; $display("FAIL store_rdata_hold: got %h want %h", bus.dm_rdata, e.rdata);
    end
    n_tests++;
    if (we_cnt != w0 + 1) begin n_fail++; $display("FAIL store_pulses: got %0d want 1", we_cnt - w0); end
    // follow-on load of the same word
    t0 = cyc;
    bus.dm_we = 1'b0;
    sb.push_back('{dm: 1'b1, err: 1'b0, rdata: 32'h1122CCDD, at: t0 + 3});
    wait_any_ack(10, got, dm, at, err);
    e = sb.pop_front();
    n_tests++;
    if (!got || dm !== e.dm || at != e.at || err !== e.err) begin
      n_fail++;
      $display("FAIL load_ack: got ack=%0b dm=%0b cyc=%0d err=%0b want dm=%0b cyc=%0d err=%0b",
               got, dm, at - t0, err, e.dm, e.at - t0, e.err);
    end
    @(negedge clk);
    bus.dm_req = 1'b0;
    m_dm_rdata = e.rdata;
    n_tests++;
    if (bus.dm_rdata !== m_dm_rdata) begin
      n_fail++; $display("FAIL load_rdata: got %h want %h", bus.dm_rdata, m_dm_rdata);
    end
  endtask

  task automatic test_arbitration();
    exp_t e; bit got, dm, err; int at, t0;
    t0 = cyc;
    bus.if_addr = 32'h0; bus.dm_addr = 32'h14; bus.dm_we = 1'b0;
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
`ifdef MEM_ARB_RR_EN
    sb.push_back('{dm: 1'b0, err: 1'b0, rdata: init_word(0), at: t0 + 3});
    sb.push_back('{dm: 1'b1, err: 1'b0, rdata: init_word(5), at: t0 + 7});
`else
    sb.push_back('{dm: 1'b1, err: 1'b0, rdata: init_word(5), at: t0 + 3});
    sb.push_back('{dm: 1'b0, err: 1'b0, rdata: init_word(0), at: t0 + 7});
`endif
    for (int k = 0; k < 2; k++) begin
      wait_any_ack(12, got, dm, at, err);
      e = sb.pop_front();
      n_tests++;
      if (!got || dm !== e.dm || at != e.at || err !== e.err) begin
        n_fail++;
        $display("FAIL arb_ack%0d: got ack=%0b dm=%0b cyc=%0d err=%0b want dm=%0b cyc=%0d err=%0b",
                 k, got, dm, at - t0, err, e.dm, e.at - t0, e.err);
      end
      @(negedge clk);
      if (e.dm) begin bus.dm_req = 1'b0; m_dm_rdata = e.rdata; end
      else      begin bus.if_req = 1'b0; m_if_rdata = e.rdata; end
      n_tests++;
      if ((e.dm ? bus.dm_rdata : bus.if_rdata) !== e.rdata) begin
        n_fail++;
        $display("FAIL arb_rdata%0d: got %h want %h", k, e.dm ? bus.dm_rdata : bus.if_rdata, e.rdata);
      end
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
  endtask

  task automatic test_misaligned();
    exp_t e; bit got, dm, err; int at, t0, w0;
    t0 = cyc; w0 = we_cnt;
    bus.dm_addr = 32'h13; bus.dm_we = 1'b0; bus.dm_req = 1'b1;
    sb.push_back('{dm: 1'b1, err: 1'b1, rdata: m_dm_rdata, at: t0 + 1});
    wait_any_ack(10, got, dm, at, err);
    e = sb.pop_front();
    n_tests++;
    if (!got || dm !== e.dm || at != e.at || err !== e.err) begin
      n_fail++;
      $display("FAIL misalign_ack: got ack=%0b dm=%0b cyc=%0d err=%0b want dm=%0b cyc=%0d err=%0b",
               got, dm, at - t0, err, e.dm, e.at - t0, e.err);
    end
    @(negedge clk);
    bus.dm_req = 1'b0;
    n_tests++;
    if (bus.dm_rdata !== e.rdata) begin
      n_fail++; $display("FAIL misalign_rdata: got %h want %h", bus.dm_rdata, e.rdata);
    end
    n_tests++;
    if (we_cnt != w0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL misalign_idle: got we=%0d busy=%b want we=0 busy=0", we_cnt - w0, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; bit got, dm, err; int at, t0, w0, a0;
    w0 = we_cnt; a0 = dmack_cnt;
    bus.dm_addr = 32'h20; bus.dm_we = 1'b1; bus.dm_be = 4'hF;
    bus.dm_wdata = 32'hDEADBEEF; bus.dm_req = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_wait: got busy=%b want 1", bus.busy); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.busy, bus.dm_ack, bus.mem_we} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_idle: got busy=%b ack=%b we=%b want 000", bus.busy, bus.dm_ack, bus.mem_we);
    end
    rst = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    m_if_rdata = 32'd0; m_dm_rdata = 32'd0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (we_cnt != w0 || dmack_cnt != a0) begin
      n_fail++; $display("FAIL rstmid_dropped: got we=%0d ack=%0d want 0 0", we_cnt - w0, dmack_cnt - a0);
    end
    n_tests++;
    if (bus.dm_rdata !== m_dm_rdata) begin
      n_fail++; $display("FAIL rstmid_rdata: got %h want %h", bus.dm_rdata, m_dm_rdata);
    end
    // fetch afterwards completes normally
    t0 = cyc;
    bus.if_addr = 32'h8; bus.if_req = 1'b1;
    sb.push_back('{dm: 1'b0, err: 1'b0, rdata: 32'h014B4820, at: t0 + 3});
    wait_any_ack(10, got, dm, at, err);
    e = sb.pop_front();
    n_tests++;
    if (!got || dm !== e.dm || at != e.at || err !== e.err) begin
      n_fail++;
      $display("FAIL rstmid_fetch: got ack=%0b dm=%0b cyc=%0d err=%0b want dm=%0b cyc=%0d err=%0b",
               got, dm, at - t0, err, e.dm, e.at - t0, e.err);
    end
    @(negedge clk);
    bus.if_req = 1'b0;
    m_if_rdata = e.rdata;
    n_tests++;
    if (bus.if_rdata !== m_if_rdata) begin
      n_fail++; $display("FAIL rstmid_fetch_rdata: got %h want %h", bus.if_rdata, m_if_rdata);
    end
  endtask

  task automatic test_back_to_back_w0();
    exp_t e; bit got; int at, t0;
    t0 = cyc;
    bus0.if_addr = 32'h0; bus0.if_req = 1'b1;
    sb.push_back('{dm: 1'b0, err: 1'b0, rdata: init_word(0), at: t0 + 1});
    sb.push_back('{dm: 1'b0, err: 1'b0, rdata: init_word(1), at: t0 + 3});
    for (int k = 0; k < 2; k++) begin
      got = 1'b0; at = -1;
      for (int n = 0; n < 6 && !got; n++) begin
        @(negedge clk);
        if (bus0.if_ack) begin got = 1'b1; at = cyc; end
      end
      e = sb.pop_front();
      n_tests++;
      if (!got || at != e.at || bus0.if_err !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_ack%0d: got ack=%0b cyc=%0d err=%b want cyc=%0d err=0",
                 k, got, at - t0, bus0.if_err, e.at - t0);
      end
      @(negedge clk);
      if (k == 0) bus0.if_addr = 32'h4;
      else        bus0.if_req  = 1'b0;
      n_tests++;
      if (bus0.if_rdata !== e.rdata) begin
        n_fail++; $display("FAIL b2b_rdata%0d: got %h want %h", k, bus0.if_rdata, e.rdata);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_req = 1'b0;  bus.if_addr = 32'd0;
    bus.dm_req = 1'b0;  bus.dm_we = 1'b0; bus.dm_be = 4'd0;
    bus.dm_addr = 32'd0; bus.dm_wdata = 32'd0;
    bus0.if_req = 1'b0; bus0.if_addr = 32'd0;
    bus0.dm_req = 1'b0; bus0.dm_we = 1'b0; bus0.dm_be = 4'd0;
    bus0.dm_addr = 32'd0; bus0.dm_wdata = 32'd0;

    test_reset();
    test_fetch();
    test_store_load();
    test_arbitration();
    test_misaligned();
    test_reset_mid();
    test_back_to_back_w0();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
